// File: rtl/mem_access_stage.sv
// MEM stage: loads/stores against an internal little-endian byte memory with a fixed access latency.
// Define MEM_MISALIGN_CHECK_EN to suppress and flag accesses that are not naturally aligned.
module mem_access_stage #(
    parameter int DEPTH_BYTES = 1024,
    parameter int ADDR_BITS   = 10,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        RegWrite,
    input  logic        MemtoReg,
    input  logic [2:0]  funct3,
    input  logic [63:0] ALU_result,
    input  logic [63:0] WriteData,
    input  logic [4:0]  rd,
    output logic        RegWrite_out,
    output logic        MemtoReg_out,
    output logic [63:0] ALU_result_out,
    output logic [63:0] ReadData,
    output logic [4:0]  rd_out,
    output logic        mem_stall,
    output logic        misaligned,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic [63:0] lat_addr;
    logic [63:0] lat_wdata;
    logic [2:0]  lat_funct3;
    logic        lat_regwrite;
    logic        lat_memtoreg;
    logic        lat_load;
    logic        lat_store;
    logic [4:0]  lat_rd;
    logic [63:0] read_data_q;

    logic [7:0]  mem [DEPTH_BYTES];

    logic                 mem_req;
    logic                 access_edge;
    logic                 mis;
    logic                 mem_we;
    logic                 load_en;
    logic [7:0]           size_mask;
    logic [63:0]          raw;
    logic [63:0]          load_val;
    logic [ADDR_BITS-1:0] byte_addr [8];

    assign mem_req     = MemRead | MemWrite;
    assign access_edge = (state == ACCESS) && (cnt == 4'd0);
    assign state_dbg   = state;

    // Byte lanes wrap modulo the memory size through the natural ADDR_BITS overflow.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            byte_addr[i] = lat_addr[ADDR_BITS-1:0] + ADDR_BITS'(i);
        end
    end

    always_comb begin
        case (lat_funct3[1:0])
            2'b00:   size_mask = 8'h01;
            2'b01:   size_mask = 8'h03;
            2'b10:   size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    end

`ifdef MEM_MISALIGN_CHECK_EN
    always_comb begin
        case (lat_funct3[1:0])
            2'b01:   mis = lat_addr[0];
            2'b10:   mis = |lat_addr[1:0];
            2'b11:   mis = |lat_addr[2:0];
            default: mis = 1'b0;
        endcase
    end
`else
    assign mis = 1'b0;
`endif

    always_comb begin
        raw = '0;
        for (int i = 0; i < 8; i++) begin
            raw[8*i +: 8] = mem[byte_addr[i]];
        end
    end

    always_comb begin
        case (lat_funct3)
            3'b000:  load_val = {{56{raw[7]}}, raw[7:0]};
            3'b001:  load_val = {{48{raw[15]}}, raw[15:0]};
            3'b010:  load_val = {{32{raw[31]}}, raw[31:0]};
            3'b011:  load_val = raw;
            3'b100:  load_val = {56'd0, raw[7:0]};
            3'b101:  load_val = {48'd0, raw[15:0]};
            3'b110:  load_val = {32'd0, raw[31:0]};
            default: load_val = 64'd0;
        endcase
    end

    // A store wins over a simultaneous read request; funct3 1xx stores keep timing but write nothing.
    assign mem_we  = access_edge && lat_store && !lat_funct3[2] && !mis && !reset;
    assign load_en = access_edge && lat_load && !mis;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mem_req) state_nxt = ACCESS;
            ACCESS:  if (cnt == 4'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt          <= 4'd0;
            lat_addr     <= 64'd0;
            lat_wdata    <= 64'd0;
            lat_funct3   <= 3'd0;
            lat_regwrite <= 1'b0;
            lat_memtoreg <= 1'b0;
            lat_load     <= 1'b0;
            lat_store    <= 1'b0;
            lat_rd       <= 5'd0;
            read_data_q  <= 64'd0;
        end else begin
            if (state == IDLE && mem_req) begin
                cnt          <= 4'(LATENCY - 1);
                lat_addr     <= ALU_result;
                lat_wdata    <= WriteData;
                lat_funct3   <= funct3;
                lat_regwrite <= RegWrite;
                lat_memtoreg <= MemtoReg;
                lat_load     <= MemRead & ~MemWrite;
                lat_store    <= MemWrite;
                lat_rd       <= rd;
            end else if (state == ACCESS && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (load_en) begin
                read_data_q <= load_val;
            end
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (mem_we && size_mask[i]) begin
                mem[byte_addr[i]] <= lat_wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        RegWrite_out   = RegWrite;
        MemtoReg_out   = MemtoReg;
        ALU_result_out = ALU_result;
        rd_out         = rd;
        mem_stall      = 1'b0;
        misaligned     = 1'b0;
        case (state)
            IDLE: begin
                mem_stall    = mem_req;
                RegWrite_out = RegWrite & ~mem_req;
            end
            ACCESS: begin
                mem_stall      = 1'b1;
                RegWrite_out   = 1'b0;
                MemtoReg_out   = lat_memtoreg;
                ALU_result_out = lat_addr;
                rd_out         = lat_rd;
            end
            DONE: begin
                RegWrite_out   = lat_regwrite & ~mis;
                MemtoReg_out   = lat_memtoreg;
                ALU_result_out = lat_addr;
                rd_out         = lat_rd;
                misaligned     = mis;
            end
            default: begin
                mem_stall = 1'b0;
            end
        endcase
    end

    assign ReadData = read_data_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage (LATENCY=2, DEPTH_BYTES=1024); adapts expectations when
// MEM_MISALIGN_CHECK_EN is defined.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite, RegWrite, MemtoReg;
    logic [2:0]  funct3;
    logic [63:0] ALU_result, WriteData;
    logic [4:0]  rd;
    logic        RegWrite_out, MemtoReg_out;
    logic [63:0] ALU_result_out, ReadData;
    logic [4:0]  rd_out;
    logic        mem_stall, misaligned;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    int stalls;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;
`ifdef MEM_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    mem_access_stage #(.DEPTH_BYTES(1024), .ADDR_BITS(10), .LATENCY(2)) dut (
        .clk(clk), .reset(reset),
        .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .funct3(funct3), .ALU_result(ALU_result), .WriteData(WriteData), .rd(rd),
        .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
        .ALU_result_out(ALU_result_out), .ReadData(ReadData), .rd_out(rd_out),
        .mem_stall(mem_stall), .misaligned(misaligned), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_op(input logic [63:0] alu, input logic [4:0] r, input logic rw);
        @(posedge clk); #1;
        MemRead = 1'b0; MemWrite = 1'b0; RegWrite = rw; MemtoReg = 1'b0;
        funct3 = 3'd0; ALU_result = alu; rd = r;
        #1;
    endtask

    // Issues one memory op, counts stall cycles, and returns sampled in the DONE cycle.
    task automatic mem_op(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                          input logic [63:0] addr, input logic [63:0] wdata, input logic [4:0] r);
        @(posedge clk); #1;
        MemRead = rd_en; MemWrite = wr_en;
        RegWrite = rd_en & ~wr_en; MemtoReg = rd_en & ~wr_en;
        funct3 = f3; ALU_result = addr; WriteData = wdata; rd = r;
        #1;
        check("bubble_regwrite", {63'd0, RegWrite_out}, 64'd0);
        stalls = 0;
        for (int i = 0; i < 20; i++) begin
            if (!mem_stall) break;
            stalls++;
            @(posedge clk); #1;
        end
        check("stall_cycles", 64'(stalls), 64'd3);
        check("done_state", {62'd0, state_dbg}, {62'd0, S_DONE});
    endtask

    initial begin
        reset = 1'b1;
        MemRead = 1'b0; MemWrite = 1'b0; RegWrite = 1'b0; MemtoReg = 1'b0;
        funct3 = 3'd0; ALU_result = 64'd0; WriteData = 64'd0; rd = 5'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("reset_state", {62'd0, state_dbg}, {62'd0, S_IDLE});
        check("reset_stall", {63'd0, mem_stall}, 64'd0);
        check("reset_readdata", ReadData, 64'd0);

        // ALU pass-through
        idle_op(64'h1234, 5'd5, 1'b1);
        check("pass_alu", ALU_result_out, 64'h1234);
        check("pass_rd", {59'd0, rd_out}, 64'd5);
        check("pass_regwrite", {63'd0, RegWrite_out}, 64'd1);
        check("pass_stall", {63'd0, mem_stall}, 64'd0);
        check("pass_readdata", ReadData, 64'd0);

        // sd then loads of each size
        mem_op(1'b0, 1'b1, 3'b011, 64'h10, 64'h8877665544332211, 5'd0);
        check("sd_regwrite", {63'd0, RegWrite_out}, 64'd0);
        check("sd_readdata", ReadData, 64'd0);
        check("sd_alu_out", ALU_result_out, 64'h10);
        check("sd_misaligned", {63'd0, misaligned}, 64'd0);

        mem_op(1'b1, 1'b0, 3'b011, 64'h10, 64'd0, 5'd7);
        check("ld_data", ReadData, 64'h8877665544332211);
        check("ld_regwrite", {63'd0, RegWrite_out}, 64'd1);
        check("ld_rd", {59'd0, rd_out}, 64'd7);
        check("ld_memtoreg", {63'd0, MemtoReg_out}, 64'd1);
        check("ld_alu_out", ALU_result_out, 64'h10);

        mem_op(1'b1, 1'b0, 3'b000, 64'h17, 64'd0, 5'd8);
        check("lb_data", ReadData, 64'hFFFFFFFFFFFFFF88);
        mem_op(1'b1, 1'b0, 3'b101, 64'h16, 64'd0, 5'd8);
        check("lhu_data", ReadData, 64'h8877);
        mem_op(1'b1, 1'b0, 3'b110, 64'h14, 64'd0, 5'd8);
        check("lwu_data", ReadData, 64'h88776655);
        mem_op(1'b1, 1'b0, 3'b010, 64'h14, 64'd0, 5'd8);
        check("lw_data", ReadData, 64'hFFFFFFFF88776655);
        mem_op(1'b1, 1'b0, 3'b001, 64'h10, 64'd0, 5'd8);
        check("lh_data", ReadData, 64'h2211);
        mem_op(1'b1, 1'b0, 3'b100, 64'h10, 64'd0, 5'd8);
        check("lbu_data", ReadData, 64'h11);

        // Wrapping sw at the top of memory (misaligned for a word)
        mem_op(1'b0, 1'b1, 3'b010, 64'h3FE, 64'hAABBCCDD, 5'd0);
        check("sw_wrap_misaligned", {63'd0, misaligned}, {63'd0, MIS_EN});
        mem_op(1'b1, 1'b0, 3'b101, 64'h0, 64'd0, 5'd9);
        check("lhu_wrap_low", ReadData, MIS_EN ? 64'h0 : 64'hAABB);
        mem_op(1'b1, 1'b0, 3'b101, 64'h3FE, 64'd0, 5'd9);
        check("lhu_wrap_top", ReadData, MIS_EN ? 64'h0 : 64'hCCDD);
        mem_op(1'b1, 1'b0, 3'b100, 64'h1000_0001, 64'd0, 5'd9);
        check("lbu_upper_ignored", ReadData, MIS_EN ? 64'h0 : 64'hAA);
        mem_op(1'b1, 1'b0, 3'b011, 64'h3FC, 64'd0, 5'd9);
        check("ld_wrap", ReadData, MIS_EN ? 64'h0 : 64'h0000AABBCCDD0000);

        // funct3 111 load yields zero
        mem_op(1'b1, 1'b0, 3'b011, 64'h10, 64'd0, 5'd10);
        check("ld_restore", ReadData, 64'h8877665544332211);
        mem_op(1'b1, 1'b0, 3'b111, 64'h10, 64'd0, 5'd10);
        check("load_f3_111", ReadData, 64'd0);
        check("load_f3_111_regwrite", {63'd0, RegWrite_out}, 64'd1);

        // Store funct3 1xx: timing only, no write
        mem_op(1'b1, 1'b0, 3'b011, 64'h10, 64'd0, 5'd10);
        mem_op(1'b0, 1'b1, 3'b100, 64'h10, 64'hFF, 5'd0);
        check("store_1xx_readdata", ReadData, 64'h8877665544332211);
        mem_op(1'b1, 1'b0, 3'b100, 64'h10, 64'd0, 5'd10);
        check("store_1xx_nowrite", ReadData, 64'h11);

        // MemRead and MemWrite together behave as a store
        mem_op(1'b1, 1'b1, 3'b000, 64'h18, 64'h5A, 5'd11);
        check("both_readdata_held", ReadData, 64'h11);
        mem_op(1'b1, 1'b0, 3'b100, 64'h18, 64'd0, 5'd11);
        check("both_store_written", ReadData, 64'h5A);

        // Reset in the middle of an sd to 0x20
        mem_op(1'b1, 1'b0, 3'b011, 64'h10, 64'd0, 5'd12);
        @(posedge clk); #1;
        MemRead = 1'b0; MemWrite = 1'b1; RegWrite = 1'b0; MemtoReg = 1'b0;
        funct3 = 3'b011; ALU_result = 64'h20; WriteData = 64'hDEADBEEFCAFEF00D;
        @(posedge clk); #1;
        check("abort_in_access", {62'd0, state_dbg}, {62'd0, S_ACCESS});
        reset = 1'b1; MemWrite = 1'b0;
        #1;
        check("abort_state", {62'd0, state_dbg}, {62'd0, S_IDLE});
        check("abort_stall", {63'd0, mem_stall}, 64'd0);
        check("abort_readdata", ReadData, 64'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        mem_op(1'b1, 1'b0, 3'b011, 64'h10, 64'd0, 5'd12);
        check("mem_kept_over_reset", ReadData, 64'h8877665544332211);
        mem_op(1'b1, 1'b0, 3'b011, 64'h20, 64'd0, 5'd12);
        check("aborted_store_dropped", ReadData, 64'd0);

        // Misaligned lw from 0x12
        mem_op(1'b1, 1'b0, 3'b011, 64'h10, 64'd0, 5'd13);
        mem_op(1'b1, 1'b0, 3'b010, 64'h12, 64'd0, 5'd13);
        check("mis_flag", {63'd0, misaligned}, {63'd0, MIS_EN});
        check("mis_regwrite", {63'd0, RegWrite_out}, {63'd0, ~MIS_EN});
        check("mis_readdata", ReadData, MIS_EN ? 64'h8877665544332211 : 64'h0000000066554433);
        idle_op(64'h55, 5'd1, 1'b1);
        check("mis_flag_cleared", {63'd0, misaligned}, 64'd0);
        check("idle_after_mis_regwrite", {63'd0, RegWrite_out}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
